// File: rtl/crack_scheduler.sv
// Key-space scheduler: hands 2^BLOCK_W-key blocks round-robin to idle ARC4 crack engines,
// stops on the first hit (lowest engine wins) or reports exhaustion.

module crack_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic set,
  input  logic done,
  input  logic found,
  output logic busy,
  output logic hit
);
  // done/found from an engine we never started are ignored
  assign hit = done & found & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    busy <= 1'b0;
    else if (clr)  busy <= 1'b0;
    else if (set)  busy <= 1'b1;
    else if (done) busy <= 1'b0;
  end
endmodule

module crack_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int KEY_W   = 24,
  parameter int BLOCK_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     rdy,
  output logic [NUM_ENG-1:0]       eng_start,
  output logic [KEY_W-1:0]         eng_base,
  output logic                     eng_abort,
  input  logic [NUM_ENG-1:0]       eng_done,
  input  logic [NUM_ENG-1:0]       eng_found,
  input  logic [NUM_ENG*KEY_W-1:0] eng_key,
  output logic [KEY_W-1:0]         key,
  output logic                     key_valid,
  output logic [2:0]               winner,
  output logic                     done
);
  localparam int PW  = $clog2(NUM_ENG);
  localparam int BLW = KEY_W - BLOCK_W + 1;
  localparam logic [BLW-1:0]   NUM_BLK  = BLW'(1) << (KEY_W - BLOCK_W);
  localparam logic [KEY_W-1:0] BLK_STEP = KEY_W'(1) << BLOCK_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [NUM_ENG-1:0] busy, hit_vec, set_vec;
  logic [KEY_W-1:0]   next_base;
  logic [BLW-1:0]     blocks_left;
  logic [PW-1:0]      rr_ptr, sel_idx, rr_nxt;
  logic               sel_ok, any_hit, launch, dispatch, exhaust, clr_all;
  logic [KEY_W-1:0]   hit_key;
  logic [2:0]         hit_win;
  int                 idx;

  assign rdy      = (state != S_RUN);
  assign launch   = (state != S_RUN) && en;
  assign any_hit  = |hit_vec;
  assign clr_all  = launch || any_hit;
  assign dispatch = (state == S_RUN) && (blocks_left != '0) && sel_ok && !any_hit;
  assign exhaust  = (state == S_RUN) && (blocks_left == '0) && (busy == '0) && (eng_done == '0);
  assign rr_nxt   = (sel_idx == PW'(NUM_ENG - 1)) ? '0 : sel_idx + PW'(1);

  // first idle engine at or after rr_ptr, wrapping modulo NUM_ENG
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (!sel_ok && !busy[idx]) begin
        sel_ok  = 1'b1;
        sel_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    set_vec = '0;
    if (dispatch) set_vec[sel_idx] = 1'b1;
  end

  // descending scan so the lowest hitting engine overrides
  always_comb begin
    hit_key = '0;
    hit_win = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_key = eng_key[i*KEY_W +: KEY_W];
        hit_win = 3'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_lane
    crack_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_all),
      .set   (set_vec[g]),
      .done  (eng_done[g]),
      .found (eng_found[g]),
      .busy  (busy[g]),
      .hit   (hit_vec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      eng_start   <= '0;
      eng_base    <= '0;
      eng_abort   <= 1'b0;
      key         <= '0;
      key_valid   <= 1'b0;
      winner      <= '0;
      done        <= 1'b0;
      next_base   <= '0;
      blocks_left <= '0;
      rr_ptr      <= '0;
    end else begin
      eng_start <= '0;
      eng_abort <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (en) begin
            state       <= S_RUN;
            key         <= '0;
            key_valid   <= 1'b0;
            winner      <= '0;
            done        <= 1'b0;
            next_base   <= '0;
            blocks_left <= NUM_BLK;
            rr_ptr      <= '0;
          end
        end
        S_RUN: begin
          if (any_hit) begin
            key       <= hit_key;
            winner    <= hit_win;
            key_valid <= 1'b1;
            done      <= 1'b1;
            eng_abort <= 1'b1;
            state     <= S_DONE;
          end else begin
            if (dispatch) begin
              eng_start   <= set_vec;
              eng_base    <= next_base;
              next_base   <= next_base + BLK_STEP;
              blocks_left <= blocks_left - BLW'(1);
              rr_ptr      <= rr_nxt;
            end
            if (exhaust) begin
              done      <= 1'b1;
              key_valid <= 1'b0;
              state     <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crack_scheduler.sv
// Scoreboard bench: small-config instance drives the dispatch/hit/exhaustion scenarios,
// default-config instance covers asynchronous reset during a run.
module tb_crack_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small configuration: 2 engines, 6-bit keys, 4-key blocks
  logic        rst_n, en, s_rdy, s_abort, s_kv, s_done;
  logic [1:0]  s_start, e_done, e_found;
  logic [5:0]  s_base, s_key;
  logic [11:0] e_key;
  logic [2:0]  s_win;

  crack_scheduler #(.NUM_ENG(2), .KEY_W(6), .BLOCK_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(s_rdy),
    .eng_start(s_start), .eng_base(s_base), .eng_abort(s_abort),
    .eng_done(e_done), .eng_found(e_found), .eng_key(e_key),
    .key(s_key), .key_valid(s_kv), .winner(s_win), .done(s_done)
  );

  // default configuration
  logic        rst_n_d, en_d, d_rdy, d_abort, d_kv, d_done;
  logic [3:0]  d_start;
  logic [23:0] d_base, d_key;
  logic [2:0]  d_win;
  logic [3:0]  d_edone = '0, d_efound = '0;
  logic [95:0] d_ekey = '0;

  crack_scheduler dut_d (
    .clk(clk), .rst_n(rst_n_d), .en(en_d), .rdy(d_rdy),
    .eng_start(d_start), .eng_base(d_base), .eng_abort(d_abort),
    .eng_done(d_edone), .eng_found(d_efound), .eng_key(d_ekey),
    .key(d_key), .key_valid(d_kv), .winner(d_win), .done(d_done)
  );

  typedef struct packed {
    logic       is_done;
    logic [1:0] start;
    logic [5:0] base;
    logic [5:0] key;
    logic       kv;
    logic [2:0] win;
    logic       abort;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_start(input logic [1:0] st, input logic [5:0] b);
    exp_t e;
    e = '0; e.start = st; e.base = b;
    q.push_back(e);
  endtask

  task automatic exp_done(input logic [5:0] k, input logic kv, input logic [2:0] w, input logic ab);
    exp_t e;
    e = '0; e.is_done = 1'b1; e.key = k; e.kv = kv; e.win = w; e.abort = ab;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] d, input logic [1:0] f, input logic [11:0] k);
    e_done = d; e_found = f; e_key = k;
    cyc(1);
    e_done = '0; e_found = '0; e_key = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic go;
    en = 1'b1;
    cyc(1);
    en = 1'b0;
  endtask

  // monitor: every start pulse and every rising done is matched against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (|s_start) begin
        if (q.size() == 0 || q[0].is_done) begin
          checks++; failures++;
          $display("FAIL unexpected_start start=%b base=%0d", s_start, s_base);
        end else begin
          e = q.pop_front();
          chk("start_onehot", 64'(s_start), 64'(e.start));
          chk("start_base", 64'(s_base), 64'(e.base));
        end
      end
      if (s_done && !done_q) begin
        if (q.size() == 0 || !q[0].is_done) begin
          checks++; failures++;
          $display("FAIL unexpected_done key=%0d kv=%b win=%0d", s_key, s_kv, s_win);
        end else begin
          e = q.pop_front();
          chk("done_key", 64'(s_key), 64'(e.key));
          chk("done_key_valid", 64'(s_kv), 64'(e.kv));
          chk("done_winner", 64'(s_win), 64'(e.win));
          chk("done_abort", 64'(s_abort), 64'(e.abort));
          chk("done_rdy", 64'(s_rdy), 64'd1);
        end
      end else if (s_abort) begin
        checks++; failures++;
        $display("FAIL stray_abort actual=1 expected=0");
      end
      done_q = s_done;
    end else begin
      done_q = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst_n_d = 1'b0; en = 1'b0; en_d = 1'b0;
    e_done = '0; e_found = '0; e_key = '0;
    cyc(3);
    chk("reset_rdy", 64'(s_rdy), 64'd1);
    chk("reset_outputs", {s_start, s_base, s_abort, s_key, s_kv, s_win, s_done}, 64'd0);
    chk("reset_d_outputs", {d_start, d_base, d_abort, d_kv, d_win, d_done}, 64'd0);
    rst_n = 1'b1; rst_n_d = 1'b1;
    cyc(2);

    // default config: reset after three dispatches, then restart from base 0
    en_d = 1'b1; cyc(1); en_d = 1'b0;
    cyc(1); chk("d_start0", {d_start, d_base}, {4'b0001, 24'h000000});
    cyc(1); chk("d_start1", {d_start, d_base}, {4'b0010, 24'h010000});
    cyc(1); chk("d_start2", {d_start, d_base}, {4'b0100, 24'h020000});
    #2 rst_n_d = 1'b0;
    #1;
    chk("d_async_clear", {d_start, d_abort, d_done, d_kv}, 64'd0);
    chk("d_async_rdy", 64'(d_rdy), 64'd1);
    cyc(2);
    rst_n_d = 1'b1;
    cyc(1);
    en_d = 1'b1; cyc(1); en_d = 1'b0;
    cyc(1); chk("d_restart", {d_start, d_base}, {4'b0001, 24'h000000});

    // 1: first two dispatches, then stall while both engines busy
    exp_start(2'b01, 6'd0); exp_start(2'b10, 6'd4);
    go();
    chk("run_rdy", 64'(s_rdy), 64'd0);
    cyc(5);
    drain("t1_drain");

    // 2: engine 0 re-fed with blocks 2 and 3, hit on block 3
    exp_start(2'b01, 6'd8);
    pulse(2'b01, 2'b00, '0); cyc(3);
    exp_start(2'b01, 6'd12);
    pulse(2'b01, 2'b00, '0); cyc(3);
    exp_done(6'd13, 1'b1, 3'd0, 1'b1);
    pulse(2'b01, 2'b01, {6'd0, 6'd13});
    chk("hit_rdy", 64'(s_rdy), 64'd1);
    cyc(3);
    drain("t2_drain");

    // 3: simultaneous hits, lowest engine wins
    exp_start(2'b01, 6'd0); exp_start(2'b10, 6'd4);
    go();
    chk("restart_cleared", {s_key, s_kv, s_win, s_done}, 64'd0);
    cyc(3);
    exp_done(6'd21, 1'b1, 3'd0, 1'b1);
    pulse(2'b11, 2'b11, {6'd26, 6'd21});
    cyc(3);
    drain("t3_drain");

    // 3b: hit on engine 1 only; found without done on engine 0 is not a hit
    exp_start(2'b01, 6'd0); exp_start(2'b10, 6'd4);
    go();
    cyc(3);
    exp_done(6'd7, 1'b1, 3'd1, 1'b1);
    pulse(2'b10, 2'b11, {6'd7, 6'd50});
    cyc(3);
    drain("t3b_drain");

    // 4/5: full exhaustion with an ignored mid-run en and a spurious done
    exp_start(2'b01, 6'd0); exp_start(2'b10, 6'd4);
    go();
    cyc(3);
    for (int k = 2; k < 16; k++) begin
      if (k == 6) begin
        go();
        chk("midrun_en_rdy", 64'(s_rdy), 64'd0);
        cyc(1);
      end
      exp_start(2'(1 << (k % 2)), 6'(4 * k));
      pulse(2'(1 << (k % 2)), 2'b00, '0);
      cyc(2);
    end
    pulse(2'b01, 2'b00, '0);
    cyc(1);
    pulse(2'b01, 2'b01, {6'd0, 6'd63});
    cyc(2);
    chk("spurious_no_done", 64'(s_done), 64'd0);
    exp_done(6'd0, 1'b0, 3'd0, 1'b0);
    pulse(2'b10, 2'b00, '0);
    cyc(3);
    drain("t4_drain");
    chk("exhaust_done_hold", {s_done, s_kv}, {62'd0, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crack_scheduler.md
Name: crack_scheduler

Overview:
- Key-space scheduler for a pool of NUM_ENG ARC4 crack engines.
- Splits the KEY_W-bit key space into blocks of 2^BLOCK_W keys and hands blocks to idle engines round-robin, via a start/done handshake.
- Stops the search on the first reported hit and aborts all engines; otherwise reports exhaustion.
- Sits between the top-level en/rdy handshake and the parallel crack engines; replaces fixed interleaved seeding.

Parameters:
- NUM_ENG, 4, number of crack engines (2..8).
- KEY_W, 24, key width in bits.
- BLOCK_W, 16, log2 of keys per block (BLOCK_W < KEY_W).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, start-search pulse; accepted only when rdy=1.
- rdy, output, 1, high in IDLE and DONE.
- eng_start, output, NUM_ENG, one-hot, one-cycle pulse: engine i begins its block.
- eng_base, output, KEY_W, first key of the dispatched block; valid with eng_start.
- eng_abort, output, 1, one-cycle pulse to all engines on a hit.
- eng_done, input, NUM_ENG, per-engine one-cycle pulse: block finished.
- eng_found, input, NUM_ENG, qualifies eng_done: key found.
- eng_key, input, NUM_ENG*KEY_W, engine i key in bits [i*KEY_W +: KEY_W]; valid with eng_done & eng_found.
- key, output, KEY_W, discovered key.
- key_valid, output, 1, key is valid.
- winner, output, 3, index of the winning engine.
- done, output, 1, search finished (hit or exhausted).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except rdy=1.
  - busy mask, next_base, rr_ptr and blocks_left all cleared.
- Registers: all outputs are registered. rdy is decoded from state.
- States: IDLE, RUN, DONE.
- IDLE/DONE, en=1:
  - Next state RUN.
  - key, key_valid, winner and done are cleared.
  - next_base=0, blocks_left=2^(KEY_W-BLOCK_W), busy=0, rr_ptr=0.
  - en while in RUN is ignored.
- RUN, dispatch (per cycle):
  - Condition: blocks_left>0, at least one busy bit is 0, and no hit this cycle.
  - Select the first idle engine, searching from rr_ptr upward with modulo NUM_ENG wrap.
  - At the edge: eng_start is one-hot for that engine, eng_base=next_base, the engine's busy bit is set, next_base += 2^BLOCK_W, blocks_left -= 1, rr_ptr = selected+1 (mod NUM_ENG).
  - At most one dispatch per cycle. The first eng_start appears 1 cycle after en is sampled.
- RUN, completion:
  - eng_done[i] with busy[i]=1 clears busy[i] at the edge.
  - The decision uses the registered busy mask, so a freed engine is re-dispatched no earlier than the following cycle.
  - eng_done[i] with busy[i]=0 is ignored, including its found bit.
- RUN, hit: any i with eng_done[i] & eng_found[i] & busy[i].
  - Lowest such i wins.
  - At the edge: key=eng_key[i], winner=i, key_valid=1, done=1, eng_abort=1 for exactly one cycle, busy=0, state=DONE.
  - No eng_start is issued in a cycle where a hit is seen, so a hit has priority over dispatch.
- RUN, exhaustion:
  - Condition: blocks_left==0, busy==0, and no eng_done this cycle.
  - At the edge: done=1, key_valid=0, state=DONE.
  - A hit in the final block takes the hit path.
- Width rules:
  - next_base wraps to 0 after the last block. It is never dispatched after the wrap because blocks_left==0.
  - blocks_left is KEY_W-BLOCK_W+1 bits wide.
- DONE: key, key_valid, winner and done hold until a new en or reset.
- Reset mid-RUN:
  - Immediate clear of all state and outputs; no abort pulse is generated.
  - Engines share rst_n, so they are reset together with the scheduler.

Test Plan:
- Parameters for 1–5: NUM_ENG=2, KEY_W=6, BLOCK_W=2 (16 blocks).
1. Start dispatch: en=1 one cycle → eng_start=01 with eng_base=0; next cycle eng_start=10 with eng_base=4; then no starts while both busy; rdy=0.
2. Hit on block 3: engine 0 is given block 3 (base 12); it pulses done+found with key 13 → next edge key=13, key_valid=1, winner=0, eng_abort high 1 cycle, done=1, rdy=1.
3. Simultaneous hits: both engines pulse done+found in the same cycle with keys 21 and 26 → winner=0, key=21, single abort pulse.
4. Exhaustion: every done has found=0 → exactly 16 eng_start pulses with bases 0,4,…,60; then done=1, key_valid=0, winner=0.
5. Spurious and mid-run events:
   - eng_done from an idle engine → no state change.
   - en asserted mid-RUN → ignored; next_base is not reset.
6. Reset mid-RUN, using default parameters: drop rst_n after 3 dispatches → outputs clear asynchronously (rdy=1); a following en restarts from eng_base=0.
